// File: rtl/jstk2_spi_responder_pkg.sv
// Shared constants, responder state type and JSTK2 packet byte builder.
package jstk2_pkg;

  localparam logic [7:0] JSTK2_CMD_SETLED = 8'h84;
  localparam logic [7:0] JSTK2_CMD_GETPOS = 8'hC0;

  localparam int POS_XL  = 0;
  localparam int POS_XH  = 1;
  localparam int POS_YL  = 2;
  localparam int POS_YH  = 3;
  localparam int POS_BTN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } resp_state_e;

  // Any index past the button byte reads as zero padding.
  function automatic logic [7:0] pkt_byte(input logic [9:0] x, input logic [9:0] y,
                                          input logic [1:0] btn, input logic [2:0] idx);
    case (int'(idx))
      POS_XL:  return x[7:0];
      POS_XH:  return {6'b0, x[9:8]};
      POS_YL:  return y[7:0];
      POS_YH:  return {6'b0, y[9:8]};
      POS_BTN: return {6'b0, btn};
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/jstk2_spi_responder_if.sv
// SPI mode-0 link between a joystick initiator and the JSTK2 responder.
// Initiator owns CS_n/SCK/MOSI, responder owns MISO; SCK idles low, data sampled on rising edges.
interface jstk2_spi_responder_if;
  logic CS_n;
  logic SCK;
  logic MOSI;
  logic MISO;

  modport master (output CS_n, output SCK, output MOSI, input MISO);
  modport slave  (input CS_n, input SCK, input MOSI, output MISO);
endinterface

// File: rtl/jstk2_spi_responder_sync.sv
// Generic N-stage synchroniser followed by a one-flop rise/fall edge detector.
module spi_in_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{INIT}};
      r_prev <= INIT;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/jstk2_spi_responder.sv
// PMOD JSTK2 emulating SPI responder: serves X/Y/button packets per CS_n frame.
// Optional LED command decode is compiled in with JSTK2_LED_CMD_EN.
module jstk2_spi_responder
  import jstk2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  jstk2_spi_responder_if.slave  spi,
  input  logic [9:0]            x_in,
  input  logic [9:0]            y_in,
  input  logic [1:0]            btn_in,
  output logic [7:0]            rx_byte,
  output logic                  rx_valid,
  output logic                  frame_done,
  output logic [23:0]           led_rgb,
  output resp_state_e           dbg_state
);
  resp_state_e r_state, w_state_nxt;
  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [9:0] r_x, r_y;
  logic [1:0] r_btn;
  logic [7:0] r_tx, r_rx_byte;
  logic [6:0] r_rx_sh;
  logic [2:0] r_bit_cnt, r_byte_cnt;
  logic r_rx_valid, r_frame_done;
  logic [7:0] w_rx_full;
  logic w_byte_done, w_frame_end, w_shift_ok;

  spi_in_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck_sync (
    .i_clk(CLK), .i_rst(RST), .i_d(spi.SCK), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
    .i_clk(CLK), .i_rst(RST), .i_d(spi.CS_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  // MOSI has the same depth as SCK so it lines up with the detected rising edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = SHIFT;
      SHIFT:   if (w_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // SCK edges coincident with CS_n release are dropped.
  assign w_shift_ok  = (r_state == SHIFT) && !w_cs_rise;
  assign w_rx_full   = {r_rx_sh, r_mosi_sync[SYNC_STAGES-1]};
  assign w_byte_done = w_shift_ok && w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_frame_end = (r_state == SHIFT) && w_cs_rise && (int'(r_byte_cnt) >= FRAME_BYTES);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_x <= '0; r_y <= '0; r_btn <= '0;
      r_tx <= '0; r_rx_sh <= '0; r_rx_byte <= '0;
      r_bit_cnt <= '0; r_byte_cnt <= '0;
      r_rx_valid <= 1'b0; r_frame_done <= 1'b0;
    end else begin
      r_rx_valid   <= w_byte_done;
      r_frame_done <= w_frame_end;
      if (r_state == LOAD) begin
        r_x        <= x_in;
        r_y        <= y_in;
        r_btn      <= btn_in;
        r_tx       <= pkt_byte(x_in, y_in, btn_in, 3'(POS_XL));
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
      end else if (w_shift_ok && w_sck_rise) begin
        r_rx_sh   <= w_rx_full[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_byte <= w_rx_full;
          if (r_byte_cnt != 3'd7) r_byte_cnt <= r_byte_cnt + 3'd1;
        end
      end else if (w_shift_ok && w_sck_fall) begin
        if (r_bit_cnt != 3'd0)
          r_tx <= {r_tx[6:0], 1'b0};
        else if (int'(r_byte_cnt) < FRAME_BYTES)
          r_tx <= pkt_byte(r_x, r_y, r_btn, r_byte_cnt);
        else
          r_tx <= 8'h00;
      end
    end
  end

`ifdef JSTK2_LED_CMD_EN
  logic [7:0]  r_cmd;
  logic [23:0] r_led_pend, r_led;

  // Colour bytes are staged and only committed once the frame completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cmd <= '0; r_led_pend <= '0; r_led <= '0;
    end else begin
      if (w_byte_done) begin
        case (r_byte_cnt)
          3'd0:    r_cmd             <= w_rx_full;
          3'd1:    r_led_pend[23:16] <= w_rx_full;
          3'd2:    r_led_pend[15:8]  <= w_rx_full;
          3'd3:    r_led_pend[7:0]   <= w_rx_full;
          default: ;
        endcase
      end
      if (w_frame_end && (r_cmd == JSTK2_CMD_SETLED)) r_led <= r_led_pend;
    end
  end
  assign led_rgb = r_led;
`else
  assign led_rgb = 24'h0;
`endif

  assign spi.MISO   = (r_state == SHIFT) ? r_tx[7] : 1'b0;
  assign rx_byte    = r_rx_byte;
  assign rx_valid   = r_rx_valid;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Self-checking bench for jstk2_spi_responder: randomized frames against a packet-level model.
module tb_jstk2_spi_responder;
  import jstk2_pkg::*;

  localparam int FRAME_BYTES = 5;
  localparam int HALF_SCK    = 8;  // SCK half period in CLK cycles (CLK/16)

  logic clk, rst;
  logic [9:0] x_in, y_in;
  logic [1:0] btn_in;
  logic [7:0] rx_byte;
  logic rx_valid, frame_done;
  logic [23:0] led_rgb;
  resp_state_e dbg_state;

  jstk2_spi_responder_if spi_if();

  jstk2_spi_responder #(.SYNC_STAGES(2), .FRAME_BYTES(FRAME_BYTES)) dut (
    .CLK(clk), .RST(rst), .spi(spi_if), .x_in(x_in), .y_in(y_in), .btn_in(btn_in),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_done(frame_done),
    .led_rgb(led_rgb), .dbg_state(dbg_state));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int n_pass = 0, n_total = 0, n_fail = 0;
  int fd_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_bytes[8];
  logic [23:0] led_exp = 24'h0;

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_byte);
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference packet: plain arithmetic on the reported values
  function automatic logic [7:0] model_byte(input int x, input int y, input int btn, input int idx);
    case (idx)
      0: return 8'(x % 256);
      1: return 8'(x / 256);
      2: return 8'(y % 256);
      3: return 8'(y / 256);
      4: return 8'(btn);
      default: return 8'h00;
    endcase
  endfunction

  // driver
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic mo, output logic mi);
    spi_if.MOSI = mo;
    wait_clk(HALF_SCK);
    mi = spi_if.MISO;
    spi_if.SCK = 1'b1;
    wait_clk(HALF_SCK);
    spi_if.SCK = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic run_frame(input int nbytes, input int extra_bits, input int chg_after,
                           input logic [9:0] chg_x);
    int sx, sy, sb;
    logic [7:0] got;
    logic mi;
    sx = int'(x_in); sy = int'(y_in); sb = int'(btn_in);
    exp_q.delete();
    for (int b = 0; b < nbytes; b++) exp_q.push_back(model_byte(sx, sy, sb, b));
    rx_q.delete();
    fd_cnt = 0;
    spi_if.CS_n = 1'b0;
    wait_clk(10);
    for (int b = 0; b < nbytes; b++) begin
      for (int k = 7; k >= 0; k--) begin
        spi_bit(tx_bytes[b][k], mi);
        got[k] = mi;
      end
      check($sformatf("miso_byte%0d", b), got, exp_q[b]);
      if (b == chg_after) x_in = chg_x;
    end
    for (int k = 0; k < extra_bits; k++) spi_bit(1'($urandom_range(0, 1)), mi);
    wait_clk(HALF_SCK);
    spi_if.CS_n = 1'b1;
    wait_clk(12);
    check("rx_valid_count", rx_q.size(), nbytes);
    for (int b = 0; b < nbytes; b++)
      check($sformatf("rx_byte%0d", b), (b < rx_q.size()) ? rx_q[b] : 8'hxx, tx_bytes[b]);
    check("frame_done_count", fd_cnt, (nbytes >= FRAME_BYTES) ? 1 : 0);
`ifdef JSTK2_LED_CMD_EN
    if (nbytes >= FRAME_BYTES && tx_bytes[0] == 8'h84)
      led_exp = {tx_bytes[1], tx_bytes[2], tx_bytes[3]};
`endif
    check("led_rgb", led_rgb, led_exp);
  endtask

  initial begin
    logic mi;
    rst = 1'b1;
    spi_if.CS_n = 1'b1; spi_if.SCK = 1'b0; spi_if.MOSI = 1'b0;
    x_in = 10'd0; y_in = 10'd0; btn_in = 2'b00;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);

    check("reset_miso", spi_if.MISO, 1'b0);
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_led", led_rgb, 24'h0);
    check("reset_state", dbg_state, IDLE);

    // basic 5-byte frame
    x_in = 10'd830; y_in = 10'd228; btn_in = 2'b01;
    fill_random();
    run_frame(5, 0, -1, 10'd0);

    // x changes mid-frame; that frame keeps its snapshot
    fill_random();
    run_frame(5, 0, 1, 10'd512);
    fill_random();
    run_frame(5, 0, -1, 10'd0);

    // long frame pads with zeros
    fill_random();
    run_frame(7, 0, -1, 10'd0);

    // aborted frame, then clean restart
    fill_random();
    run_frame(3, 4, -1, 10'd0);
    fill_random();
    run_frame(5, 0, -1, 10'd0);

    // LED command, short LED frame, other command
    tx_bytes[0] = 8'h84; tx_bytes[1] = 8'h10; tx_bytes[2] = 8'h20;
    tx_bytes[3] = 8'h30; tx_bytes[4] = 8'h00;
    run_frame(5, 0, -1, 10'd0);
    tx_bytes[0] = 8'h84; tx_bytes[1] = 8'hAA; tx_bytes[2] = 8'hBB; tx_bytes[3] = 8'hCC;
    run_frame(4, 0, -1, 10'd0);
    fill_random();
    tx_bytes[0] = 8'hC0;
    run_frame(5, 0, -1, 10'd0);

    // randomized frames
    for (int n = 0; n < 6; n++) begin
      x_in = 10'($urandom_range(0, 1023));
      y_in = 10'($urandom_range(0, 1023));
      btn_in = 2'($urandom_range(0, 3));
      fill_random();
      if ($urandom_range(0, 1) == 1) tx_bytes[0] = 8'h84;
      run_frame(int'($urandom_range(1, 7)), int'($urandom_range(0, 3)), -1, 10'd0);
    end

    // reset during bit 5 of byte2
    x_in = 10'd1023; y_in = 10'd0; btn_in = 2'b11;
    spi_if.CS_n = 1'b0;
    wait_clk(10);
    for (int k = 0; k < 16 + 5; k++) spi_bit(1'b1, mi);
    spi_if.MOSI = 1'b1;
    wait_clk(HALF_SCK);
    spi_if.SCK = 1'b1;
    wait_clk(3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_miso", spi_if.MISO, 1'b0);
    check("rst_mid_rx_byte", rx_byte, 8'h00);
    check("rst_mid_rx_valid", rx_valid, 1'b0);
    check("rst_mid_frame_done", frame_done, 1'b0);
    check("rst_mid_led", led_rgb, 24'h0);
    check("rst_mid_state", dbg_state, IDLE);
    led_exp = 24'h0;
    spi_if.SCK = 1'b0;
    spi_if.CS_n = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    fill_random();
    run_frame(5, 0, -1, 10'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
